// File: rtl/frame_sync_deserializer.sv
// rtl/frame_sync_deserializer.sv - framed serial-to-parallel front end with sync hunt, verify and flywheel lock
//
// Purpose:
//   Hunts the serial bit stream for SYNC_WORD, confirms the frame alignment on
//   LOCK_COUNT further correctly placed syncs, then emits each payload word with
//   a one-cycle ready strobe. While locked, up to MISS_LIMIT-1 consecutive bad
//   syncs are tolerated on frame timing; MISS_LIMIT consecutive misses drop lock.
//
// Ports:
//   clkA        in   1  system clock, rising edge
//   reset       in   1  asynchronous active-high reset
//   i_enable    in   1  bit-valid qualifier for i_data
//   i_data      in   1  serial input bit, MSB of each word first
//   o_data      out  N  last completed payload word (held between strobes)
//   o_ready     out  1  one-cycle strobe, o_data updated
//   o_locked    out  1  frame alignment locked
//   o_sync_err  out  1  one-cycle pulse, sync mismatch while locked

module frame_sync_deserializer #(
    parameter int             N             = 8,
    parameter logic [N-1:0]   SYNC_WORD     = 8'hB8,
    parameter int             PAYLOAD_WORDS = 4,
    parameter int             LOCK_COUNT    = 2,
    parameter int             MISS_LIMIT    = 3
) (
    input  logic         clkA,
    input  logic         reset,
    input  logic         i_enable,
    input  logic         i_data,
    output logic [N-1:0] o_data,
    output logic         o_ready,
    output logic         o_locked,
    output logic         o_sync_err
);

    // Frame position is kept as (word index, bit index within word). Words
    // 0..PAYLOAD_WORDS-1 are payload, word PAYLOAD_WORDS is the sync word.
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(PAYLOAD_WORDS + 1);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);
    localparam logic [WW-1:0] SYNC_IDX  = WW'(PAYLOAD_WORDS);
    localparam logic [CW-1:0] CONF_DONE = CW'(LOCK_COUNT);
    localparam logic [MW-1:0] MISS_DONE = MW'(MISS_LIMIT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [WW-1:0]  word_q, word_d;
    logic [CW-1:0]  conf_q, conf_d;
    logic [MW-1:0]  miss_q, miss_d;
    logic [N-1:0]   data_q, data_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;

    logic [N-1:0]   cand;
    logic           last_bit;
    logic           at_sync;
    logic           sync_ok;

    always_ff @(posedge clkA or posedge reset) begin
        if (reset) begin
            state_q <= ST_HUNT;
            sr_q    <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            conf_q  <= '0;
            miss_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            conf_q  <= conf_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        word_d   = word_q;
        conf_d   = conf_q;
        miss_d   = miss_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;

        // cand is the word ending with the bit being sampled on this edge.
        cand     = {sr_q[N-2:0], i_data};
        last_bit = (bit_q == LAST_BIT);
        at_sync  = last_bit && (word_q == SYNC_IDX);
        sync_ok  = (cand == SYNC_WORD);

        if (i_enable) begin
            sr_d = cand;

            if (last_bit) begin
                bit_d  = '0;
                word_d = at_sync ? '0 : word_q + WW'(1);
            end else begin
                bit_d  = bit_q + BW'(1);
            end

            unique case (state_q)
                ST_HUNT: begin
                    if (sync_ok) begin
                        // Next enabled bit is payload bit 0 of this frame.
                        state_d = ST_VERIFY;
                        bit_d   = '0;
                        word_d  = '0;
                        conf_d  = '0;
                    end
                end
                ST_VERIFY: begin
                    if (at_sync) begin
                        if (sync_ok) begin
                            conf_d = conf_q + CW'(1);
                            if (conf_q + CW'(1) == CONF_DONE) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (at_sync) begin
                        if (sync_ok) begin
                            miss_d = '0;
                        end else begin
                            err_d  = 1'b1;
                            miss_d = miss_q + MW'(1);
                            if (miss_q + MW'(1) == MISS_DONE) begin
                                state_d = ST_HUNT;
                            end
                        end
                    end else if (last_bit) begin
                        ready_d = 1'b1;
                        data_d  = cand;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign o_data     = data_q;
    assign o_ready    = ready_q;
    assign o_locked   = (state_q == ST_LOCKED);
    assign o_sync_err = err_q;

endmodule

// File: tb/tb_frame_sync_deserializer.sv
// tb/tb_frame_sync_deserializer.sv - self-checking bench for frame_sync_deserializer

module tb_frame_sync_deserializer;

    logic       clkA;
    logic       reset;
    logic       i_enable;
    logic       i_data;
    logic [7:0] o_data;
    logic       o_ready;
    logic       o_locked;
    logic       o_sync_err;

    frame_sync_deserializer dut (
        .clkA       (clkA),
        .reset      (reset),
        .i_enable   (i_enable),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_ready    (o_ready),
        .o_locked   (o_locked),
        .o_sync_err (o_sync_err)
    );

    initial clkA = 1'b0;
    always #5 clkA = ~clkA;

    int checks = 0;
    int errors = 0;

    // Reference model: position counted in bits within a 40-bit frame.
    logic [7:0] m_sr;
    logic       m_hunting;
    logic       m_locked;
    int         m_confirms;
    int         m_misses;
    int         m_pos;
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_err;

    // Observed pulse counters for the frame-level table checks.
    int         seen_ready;
    int         seen_err;
    logic [7:0] ready_q[$];

    typedef struct {
        logic [7:0]  sync;
        logic [31:0] pay;
        int          exp_ready;
        int          exp_err;
        logic        exp_locked;
        logic [7:0]  exp_data;
    } frame_vec_t;

    frame_vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr       = 8'h00;
        m_hunting  = 1'b1;
        m_locked   = 1'b0;
        m_confirms = 0;
        m_misses   = 0;
        m_pos      = 0;
        m_data     = 8'h00;
        m_ready    = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic d);
        logic [7:0] cand;
        m_ready = 1'b0;
        m_err   = 1'b0;
        if (en) begin
            cand = {m_sr[6:0], d};
            m_sr = cand;
            if (m_hunting) begin
                if (cand == 8'hB8) begin
                    m_hunting  = 1'b0;
                    m_confirms = 0;
                    m_pos      = 0;
                end
            end else begin
                if (m_pos == 39) begin
                    if (cand == 8'hB8) begin
                        if (m_locked) begin
                            m_misses = 0;
                        end else begin
                            m_confirms++;
                            if (m_confirms == 2) begin
                                m_locked = 1'b1;
                                m_misses = 0;
                            end
                        end
                    end else if (!m_locked) begin
                        m_hunting = 1'b1;
                    end else begin
                        m_err = 1'b1;
                        m_misses++;
                        if (m_misses == 3) begin
                            m_locked  = 1'b0;
                            m_hunting = 1'b1;
                        end
                    end
                end else if (m_locked && (m_pos % 8 == 7)) begin
                    m_ready = 1'b1;
                    m_data  = cand;
                end
                m_pos = (m_pos + 1) % 40;
            end
        end
    endtask

    task automatic drive_bit(input logic en, input logic d);
        i_enable = en;
        i_data   = d;
        @(posedge clkA);
        model_step(en, d);
        #1;
        check("o_ready",    32'(o_ready),    32'(m_ready));
        check("o_sync_err", 32'(o_sync_err), 32'(m_err));
        check("o_locked",   32'(o_locked),   32'(m_locked));
        check("o_data",     32'(o_data),     32'(m_data));
        if (o_ready) begin
            seen_ready++;
            ready_q.push_back(o_data);
        end
        if (o_sync_err) seen_err++;
    endtask

    // gap: 0 = continuous, 1 = idle cycle after every bit, 2 = random idles
    task automatic send_frame(input logic [7:0] sync, input logic [31:0] pay, input int gap);
        logic [39:0] fr;
        fr = {sync, pay};
        for (int i = 39; i >= 0; i--) begin
            if (gap == 2) begin
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(0, 3) == 0) drive_bit(1'b0, 1'($urandom));
                end
            end
            drive_bit(1'b1, fr[i]);
            if (gap == 1) drive_bit(1'b0, 1'($urandom));
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        i_enable = 1'b0;
        i_data   = 1'b0;
        @(posedge clkA);
        @(posedge clkA);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_table(input int gap, input string tag);
        for (int f = 0; f < 11; f++) begin
            seen_ready = 0;
            seen_err   = 0;
            send_frame(vecs[f].sync, vecs[f].pay, gap);
            check({tag, "_frame_ready_count"}, 32'(seen_ready), 32'(vecs[f].exp_ready));
            check({tag, "_frame_err_count"},   32'(seen_err),   32'(vecs[f].exp_err));
            check({tag, "_frame_locked"},      32'(o_locked),   32'(vecs[f].exp_locked));
            check({tag, "_frame_data"},        32'(o_data),     32'(vecs[f].exp_data));
        end
    endtask

    initial begin
        vecs[0]  = '{8'hB8, 32'h11223344, 0, 0, 1'b0, 8'h00};
        vecs[1]  = '{8'hB8, 32'h11223344, 0, 0, 1'b0, 8'h00};
        vecs[2]  = '{8'hB8, 32'h11223344, 4, 0, 1'b1, 8'h44};
        vecs[3]  = '{8'hB9, 32'hA1B2C3D4, 4, 1, 1'b1, 8'hD4};
        vecs[4]  = '{8'hB8, 32'h55667788, 4, 0, 1'b1, 8'h88};
        vecs[5]  = '{8'hB9, 32'h0F1E2D3C, 4, 1, 1'b1, 8'h3C};
        vecs[6]  = '{8'hB9, 32'h99AABBCC, 4, 1, 1'b1, 8'hCC};
        vecs[7]  = '{8'hB9, 32'h11223344, 0, 1, 1'b0, 8'hCC};
        vecs[8]  = '{8'hB8, 32'h11223344, 0, 0, 1'b0, 8'hCC};
        vecs[9]  = '{8'hB8, 32'h11223344, 0, 0, 1'b0, 8'hCC};
        vecs[10] = '{8'hB8, 32'hDEADBEEF, 4, 0, 1'b1, 8'hEF};

        reset    = 1'b1;
        i_enable = 1'b0;
        i_data   = 1'b0;
        #1;
        check("reset_o_data",     32'(o_data),     32'h0);
        check("reset_o_ready",    32'(o_ready),    32'h0);
        check("reset_o_locked",   32'(o_locked),   32'h0);
        check("reset_o_sync_err", 32'(o_sync_err), 32'h0);
        do_reset();

        // Continuous enable: acquisition, flywheel, loss and relock.
        ready_q.delete();
        run_table(0, "cont");
        check("cont_first_ready_data", 32'(ready_q[0]), 32'h11);
        check("cont_second_ready_data", 32'(ready_q[1]), 32'h22);

        // Asynchronous reset mid-frame while locked, checked before any edge.
        for (int i = 0; i < 13; i++) drive_bit(1'b1, 1'($urandom));
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_o_data",     32'(o_data),     32'h0);
        check("async_rst_o_ready",    32'(o_ready),    32'h0);
        check("async_rst_o_locked",   32'(o_locked),   32'h0);
        check("async_rst_o_sync_err", 32'(o_sync_err), 32'h0);
        model_reset();
        #2;
        reset = 1'b0;

        // Same stream with an idle cycle after every enabled bit.
        do_reset();
        run_table(1, "gap");

        // False sync in the preamble at the wrong offset.
        do_reset();
        ready_q.delete();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] pre;
            pre = 8'hB8;
            drive_bit(1'b1, pre[i]);
        end
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        for (int f = 0; f < 5; f++) send_frame(8'hB8, 32'h11223344, 0);
        check("false_sync_ready_count", 32'(ready_q.size()), 32'd8);
        if (ready_q.size() == 8) begin
            check("false_sync_word0", 32'(ready_q[0]), 32'h11);
            check("false_sync_word1", 32'(ready_q[1]), 32'h22);
            check("false_sync_word3", 32'(ready_q[3]), 32'h44);
            check("false_sync_word4", 32'(ready_q[4]), 32'h11);
        end
        check("false_sync_locked", 32'(o_locked), 32'h1);

        // Randomized frames: corrupted syncs, slips, random idles and payloads.
        do_reset();
        for (int f = 0; f < 150; f++) begin
            logic [7:0] s;
            s = 8'hB8;
            if ($urandom_range(0, 5) == 0) s = s ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 3; k++) drive_bit(1'b1, 1'($urandom));
            end
            send_frame(s, $urandom, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
